// File: rtl/seg7_scan_mux.sv
// Multi-digit seven-segment scan controller: selects one of NCH 32-bit channels,
// snapshots it once per frame and time-multiplexes DIGITS hex nibbles onto a common-anode display.
module seg7_scan_mux #(
  parameter int DIGITS   = 8,
  parameter int NCH      = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 4,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*32-1:0] ch_data,
  input  logic [SW-1:0]     sel,
  input  logic              lz_blank,
  input  logic              freeze,
  output logic [7:0]        ca,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       snap_q, snap_d;
  logic              frozen_q, frozen_d;
  logic              blank_q, blank_d;
  logic              first_q, first_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        ca_q, ca_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end, frame_end, load, dead, lz_digit, dp_n;
  logic              in_range;
  logic [31:0]       chosen;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic [DIGITS-1:0] upper_zero;
  logic              zero_run;

  always_comb begin
    chosen   = '0;
    in_range = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (sel == SW'(c)) begin
        chosen   = ch_data[c*32 +: 32];
        in_range = 1'b1;
      end
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of the snapshot are all zero
  always_comb begin
    nib        = '0;
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      zero_run = zero_run && (snap_q[(DIGITS-1-j)*4 +: 4] == 4'h0);
      upper_zero[DIGITS-1-j] = zero_run;
      if (idx_q == IW'(j)) nib = snap_q[j*4 +: 4];
    end
  end

  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  always_comb begin
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    load      = first_q || frame_end;

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

    snap_d   = snap_q;
    frozen_d = frozen_q;
    blank_d  = blank_q;
    first_d  = 1'b0;
    if (load) begin
      frozen_d = freeze;
      blank_d  = !in_range;
      if (!freeze && in_range) snap_d = chosen;
    end
    frame_done_d = frame_end;
  end

  // Outputs are computed from the current state and registered, giving a one-cycle lag
  always_comb begin
    dead     = (int'(cnt_q) < DEAD);
    lz_digit = lz_blank && (idx_q != '0) && upper_zero[idx_q];
    dp_n     = !(frozen_q && (idx_q == IW'(DIGITS - 1)));

    an_d = '1;
    ca_d = 8'hFF;
    if (!dead) begin
      if (!blank_q) an_d[idx_q] = 1'b0;
      ca_d = {dp_n, lz_digit ? 7'h7F : seg};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      frozen_q     <= 1'b0;
      blank_q      <= 1'b0;
      first_q      <= 1'b1;
      an_q         <= '1;
      ca_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      frozen_q     <= frozen_d;
      blank_q      <= blank_d;
      first_q      <= first_d;
      an_q         <= an_d;
      ca_q         <= ca_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign ca         = ca_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: table-driven frame checks plus hand-written
// sequences for snapshot consistency, freeze, out-of-range select and mid-scan reset.
module tb_seg7_scan_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ch_data;
  logic [1:0]   sel, sel3;
  logic         lz_blank, freeze;
  logic [7:0]   ca, ca3, an, an3;
  logic         frame_done, frame_done3;

  int n_cmp = 0;
  int n_err = 0;

  seg7_scan_mux #(.DIGITS(8), .NCH(4), .SCAN_DIV(8), .DEAD(2)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .sel(sel),
    .lz_blank(lz_blank), .freeze(freeze),
    .ca(ca), .an(an), .frame_done(frame_done)
  );

  seg7_scan_mux #(.DIGITS(8), .NCH(3), .SCAN_DIV(8), .DEAD(2)) dut3 (
    .clk(clk), .reset(reset), .ch_data(ch_data[95:0]), .sel(sel3),
    .lz_blank(lz_blank), .freeze(freeze),
    .ca(ca3), .an(an3), .frame_done(frame_done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        lz;
    logic [63:0] exp_ca;  // digit d expected ca at [8d+7:8d]
  } vec_t;

  vec_t vec [7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_done && t < 200);
    n_cmp++;
    if (!frame_done) begin
      n_err++;
      $display("FAIL wait_frame: got no frame_done expected pulse within 200 cycles");
    end
  endtask

  // Called just after a frame-start edge; sample k reflects state k-1 cycles after it
  task automatic check_frame(input logic [63:0] exp, input logic blank3, input int chg_k,
                             input logic [31:0] chg_val, input logic [1:0] chg_sel3);
    int c, d;
    logic [7:0] ean, eca;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      c = (k - 1) % 8;
      d = (k - 1) / 8;
      if (c < 2) begin
        ean = 8'hFF;
        eca = 8'hFF;
      end else begin
        ean = ~(8'h01 << d);
        eca = exp[d*8 +: 8];
      end
      chk("an", an, ean);
      chk("ca", ca, eca);
      chk("an3", an3, blank3 ? 8'hFF : ean);
      chk("frame_done", {7'b0, frame_done}, (k == 64) ? 8'h01 : 8'h00);
      if (k == chg_k) begin
        ch_data[31:0] = chg_val;
        sel3 = chg_sel3;
      end
    end
  endtask

  initial begin
    vec[0] = '{32'h0123_89AF, 2'd0, 1'b0, 64'hC0F9A4B0_8090888E};
    vec[1] = '{32'h0000_00A0, 2'd1, 1'b1, 64'hFFFFFFFF_FFFF88C0};
    vec[2] = '{32'h0000_00A0, 2'd1, 1'b0, 64'hC0C0C0C0_C0C088C0};
    vec[3] = '{32'h0000_0000, 2'd2, 1'b1, 64'hFFFFFFFF_FFFFFFC0};
    vec[4] = '{32'hDEAD_BEEF, 2'd3, 1'b1, 64'hA18688A1_8386868E};
    vec[5] = '{32'h0005_0000, 2'd0, 1'b1, 64'hFFFFFF92_C0C0C0C0};
    vec[6] = '{32'h8000_0000, 2'd2, 1'b1, 64'h80C0C0C0_C0C0C0C0};

    reset    = 1'b0;
    ch_data  = {4{32'hFFFF_FFFF}};
    ch_data[31:0] = 32'h0123_89AF;
    sel      = 2'd0;
    sel3     = 2'd0;
    lz_blank = 1'b0;
    freeze   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", an, 8'hFF);
    chk("reset_ca", ca, 8'hFF);
    chk("reset_frame_done", {7'b0, frame_done}, 8'h00);

    // Scan and decode straight out of reset: first anode at cycle 3
    reset = 1'b1;
    check_frame(vec[0].exp_ca, 1'b0, -1, ch_data[31:0], 2'd0);

    for (int t = 0; t < 7; t++) begin
      ch_data = {4{32'hFFFF_FFFF}};
      ch_data[vec[t].sel*32 +: 32] = vec[t].data;
      sel      = vec[t].sel;
      lz_blank = vec[t].lz;
      wait_frame();
      check_frame(vec[t].exp_ca, 1'b0, -1, ch_data[31:0], 2'd0);
    end

    // Snapshot stays consistent when ch0 changes while digit 3 is shown
    ch_data[31:0] = 32'h1111_1111;
    sel = 2'd0;
    lz_blank = 1'b0;
    wait_frame();
    check_frame({8{8'hF9}}, 1'b0, 28, 32'h2222_2222, 2'd0);
    check_frame({8{8'hA4}}, 1'b0, -1, 32'h2222_2222, 2'd0);

    // Out-of-range select on the NCH=3 instance blanks one whole frame
    sel3 = 2'd3;
    wait_frame();
    check_frame({8{8'hA4}}, 1'b1, 10, 32'h2222_2222, 2'd0);
    check_frame({8{8'hA4}}, 1'b0, -1, 32'h2222_2222, 2'd0);

    // Freeze across a frame start holds the old value and lights dp on digit 7
    ch_data[31:0] = 32'h3333_3333;
    wait_frame();
    freeze = 1'b1;
    ch_data[31:0] = 32'h4444_4444;
    check_frame({8{8'hB0}}, 1'b0, -1, 32'h4444_4444, 2'd0);
    freeze = 1'b0;
    check_frame({8'h30, {7{8'hB0}}}, 1'b0, -1, 32'h4444_4444, 2'd0);
    check_frame({8{8'h99}}, 1'b0, -1, 32'h4444_4444, 2'd0);

    // Asynchronous reset at digit 5, cnt 4
    repeat (44) @(negedge clk);
    chk("pre_reset_an", an, 8'hDF);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_an", an, 8'hFF);
    chk("async_reset_an3", an3, 8'hFF);
    chk("async_reset_ca", ca, 8'hFF);
    chk("async_reset_frame_done", {7'b0, frame_done}, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_frame({8{8'h99}}, 1'b0, -1, 32'h4444_4444, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
